// File: rtl/enigma_pkg.sv
// Shared constants for the Enigma datapath: alphabet geometry, rotor notch
// positions and the lookup direction encoding.
package enigma_pkg;

    localparam int ALPHA_DEF = 26;
    localparam int W_DEF     = 6;

    // Position at which a step carries into the next rotor ('Q','E','V','J','Z')
    localparam int NOTCH_I   = 16;
    localparam int NOTCH_II  = 4;
    localparam int NOTCH_III = 21;
    localparam int NOTCH_IV  = 9;
    localparam int NOTCH_V   = 25;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

endpackage

// File: rtl/mod_addsub.sv
// Combinational modular add/subtract for operands already reduced below ALPHA.
// One compare-and-correct step replaces any division.
module mod_addsub
    import enigma_pkg::*;
#(
    parameter int ALPHA = ALPHA_DEF,
    parameter int W     = W_DEF
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y
);

    localparam logic [W:0] ALPHA_X = (W+1)'(ALPHA);

    logic [W:0] w_sum;
    logic [W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // MSB of the difference is the borrow, i.e. a < b
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_y = '0;
        if (i_sub) begin
            o_y = w_diff[W] ? W'(w_diff + ALPHA_X) : w_diff[W-1:0];
        end else begin
            o_y = (w_sum >= ALPHA_X) ? W'(w_sum - ALPHA_X) : w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/rotor_stage.sv
// Pipelined Enigma rotor stage: loadable forward/inverse wiring, position
// register with notch carry, and a two-stage lookup in either direction.
module rotor_stage
    import enigma_pkg::*;
#(
    parameter int ALPHA = ALPHA_DEF,
    parameter int W     = W_DEF,
    parameter int NOTCH = NOTCH_I
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_cfg_we,
    input  logic [W-1:0] i_cfg_addr,
    input  logic [W-1:0] i_cfg_data,
    input  logic [W-1:0] i_ring_set,
    input  logic         i_pos_load,
    input  logic [W-1:0] i_pos_value,
    input  logic         i_step,
    input  logic         i_in_valid,
    input  logic         i_in_dir,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    output logic         o_out_err,
    output logic         o_carry_out,
    output logic [W-1:0] o_pos
);

    localparam logic [W-1:0] ALPHA_W  = W'(ALPHA);
    localparam logic [W-1:0] ALPHA_M1 = W'(ALPHA - 1);
    localparam logic [W-1:0] NOTCH_W  = W'(NOTCH);

    logic [W-1:0] r_fwd [ALPHA];
    logic [W-1:0] r_inv [ALPHA];
    logic [W-1:0] r_pos;
    logic         r_carry;

    logic         r_s1_valid;
    logic         r_s1_err;
    dir_e         r_s1_dir;
    logic [W-1:0] r_s1_idx;
    logic [W-1:0] r_s1_shift;

    logic         r_out_valid;
    logic         r_out_err;
    logic [W-1:0] r_out_data;

    logic [W-1:0] w_shift;
    logic [W-1:0] w_idx;
    logic [W-1:0] w_t;
    logic [W-1:0] w_out;
    logic         w_err;
    logic         w_cfg_ok;

    assign w_err    = (i_in_data >= ALPHA_W);
    assign w_cfg_ok = i_cfg_we && (i_cfg_addr < ALPHA_W) && (i_cfg_data < ALPHA_W);

    mod_addsub #(.ALPHA(ALPHA), .W(W)) u_shift (
        .i_a(r_pos), .i_b(i_ring_set), .i_sub(1'b1), .o_y(w_shift)
    );

    mod_addsub #(.ALPHA(ALPHA), .W(W)) u_idx (
        .i_a(i_in_data), .i_b(w_shift), .i_sub(1'b0), .o_y(w_idx)
    );

    mod_addsub #(.ALPHA(ALPHA), .W(W)) u_out (
        .i_a(w_t), .i_b(r_s1_shift), .i_sub(1'b1), .o_y(w_out)
    );

    // Both tables are rewritten together so inv stays the inverse of fwd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALPHA; i++) begin
                r_fwd[i] <= W'(i);
                r_inv[i] <= W'(i);
            end
        end else if (w_cfg_ok) begin
            for (int i = 0; i < ALPHA; i++) begin
                if (i_cfg_addr == W'(i)) r_fwd[i] <= i_cfg_data;
                if (i_cfg_data == W'(i)) r_inv[i] <= i_cfg_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (i_pos_load) begin
                if (i_pos_value < ALPHA_W) r_pos <= i_pos_value;
            end else if (i_step) begin
                r_pos   <= (r_pos == ALPHA_M1) ? '0 : r_pos + 1'b1;
                r_carry <= (r_pos == NOTCH_W);
            end
        end
    end

    // Stage 1 captures the pre-update position via w_shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_dir   <= DIR_FWD;
            r_s1_idx   <= '0;
            r_s1_shift <= '0;
        end else begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_err   <= w_err;
                r_s1_dir   <= dir_e'(i_in_dir);
                r_s1_idx   <= w_err ? '0 : w_idx;
                r_s1_shift <= w_shift;
            end
        end
    end

    always_comb begin
        w_t = '0;
        for (int i = 0; i < ALPHA; i++) begin
            if (r_s1_idx == W'(i)) w_t = (r_s1_dir == DIR_REV) ? r_inv[i] : r_fwd[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_err  <= r_s1_err;
                r_out_data <= r_s1_err ? '0 : w_out;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_err   = r_out_err;
    assign o_carry_out = r_carry;
    assign o_pos       = r_pos;

endmodule

// File: tb/tb_rotor_stage.sv
// Directed bench for rotor_stage: identity, rotor I wiring, offsets, stepping,
// error path and mid-flight reset, with hand-computed expected values.
module tb_rotor_stage;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_cfg_we = 1'b0;
    logic [W-1:0] i_cfg_addr = '0;
    logic [W-1:0] i_cfg_data = '0;
    logic [W-1:0] i_ring_set = '0;
    logic         i_pos_load = 1'b0;
    logic [W-1:0] i_pos_value = '0;
    logic         i_step = 1'b0;
    logic         i_in_valid = 1'b0;
    logic         i_in_dir = 1'b0;
    logic [W-1:0] i_in_data = '0;
    logic         o_out_valid;
    logic [W-1:0] o_out_data;
    logic         o_out_err;
    logic         o_carry_out;
    logic [W-1:0] o_pos;

    int tests = 0;
    int fails = 0;

    rotor_stage #(.ALPHA(26), .W(W), .NOTCH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .i_ring_set(i_ring_set), .i_pos_load(i_pos_load), .i_pos_value(i_pos_value),
        .i_step(i_step), .i_in_valid(i_in_valid), .i_in_dir(i_in_dir), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_err(o_out_err),
        .o_carry_out(o_carry_out), .o_pos(o_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic dir, input int data, input int exp_data,
                          input logic exp_err, input string tag);
        i_in_valid = 1'b1;
        i_in_dir   = dir;
        i_in_data  = W'(data);
        tick();
        i_in_valid = 1'b0;
        check({tag, "_v_n1"}, 32'(o_out_valid), 32'd0);
        tick();
        check({tag, "_v_n2"}, 32'(o_out_valid), 32'd1);
        check({tag, "_data"}, 32'(o_out_data), 32'(exp_data));
        check({tag, "_err"}, 32'(o_out_err), 32'(exp_err));
        tick();
        check({tag, "_v_n3"}, 32'(o_out_valid), 32'd0);
    endtask

    task automatic load_pos(input int v);
        i_pos_load  = 1'b1;
        i_pos_value = W'(v);
        tick();
        i_pos_load  = 1'b0;
    endtask

    initial begin
        string wiring;
        int    exp_b2b [3];
        wiring  = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        exp_b2b = '{4, 10, 12};

        repeat (2) @(posedge clk);
        #1;
        check("rst_pos", 32'(o_pos), 32'd0);
        check("rst_valid", 32'(o_out_valid), 32'd0);
        check("rst_data", 32'(o_out_data), 32'd0);
        check("rst_err", 32'(o_out_err), 32'd0);
        check("rst_carry", 32'(o_carry_out), 32'd0);
        rst_n = 1'b1;
        tick();

        lookup(1'b0, 7, 7, 1'b0, "id_fwd7");
        lookup(1'b1, 7, 7, 1'b0, "id_rev7");

        // out-of-range data must not corrupt the identity table
        i_cfg_we = 1'b1; i_cfg_addr = 6'd3; i_cfg_data = 6'd27;
        tick();
        i_cfg_we = 1'b0;
        lookup(1'b0, 3, 3, 1'b0, "cfg_bad");

        for (int i = 0; i < 26; i++) begin
            i_cfg_we   = 1'b1;
            i_cfg_addr = W'(i);
            i_cfg_data = W'(wiring[i] - 8'd65);
            tick();
        end
        i_cfg_we = 1'b0;

        lookup(1'b0, 0, 4, 1'b0, "r1_fwd0");
        lookup(1'b1, 4, 0, 1'b0, "r1_rev4");
        lookup(1'b1, 10, 1, 1'b0, "r1_rev10");
        lookup(1'b0, 7, 16, 1'b0, "r1_fwd7");

        for (int k = 0; k < 5; k++) begin
            i_in_valid = (k < 3);
            i_in_dir   = 1'b0;
            i_in_data  = W'(k);
            tick();
            if (k == 0 || k == 4) begin
                check("b2b_idle", 32'(o_out_valid), 32'd0);
            end else begin
                check("b2b_valid", 32'(o_out_valid), 32'd1);
                check("b2b_data", 32'(o_out_data), 32'(exp_b2b[k-1]));
            end
        end
        i_in_valid = 1'b0;

        load_pos(1);
        check("pos1", 32'(o_pos), 32'd1);
        lookup(1'b0, 0, 9, 1'b0, "p1_fwd0");
        lookup(1'b1, 9, 0, 1'b0, "p1_rev9");

        load_pos(0);
        i_ring_set = 6'd1;
        lookup(1'b0, 0, 10, 1'b0, "ring1_fwd0");
        i_ring_set = 6'd0;

        load_pos(16);
        check("pos16", 32'(o_pos), 32'd16);
        check("load_nocarry", 32'(o_carry_out), 32'd0);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check("step17_pos", 32'(o_pos), 32'd17);
        check("step17_carry", 32'(o_carry_out), 32'd1);
        tick();
        check("step17_carry_end", 32'(o_carry_out), 32'd0);

        load_pos(25);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check("wrap_pos", 32'(o_pos), 32'd0);
        check("wrap_carry", 32'(o_carry_out), 32'd0);
        tick();
        check("wrap_carry2", 32'(o_carry_out), 32'd0);

        load_pos(5);
        load_pos(30);
        check("badload_pos", 32'(o_pos), 32'd5);

        // lookup must see pos 0, not the stepped pos 1 (which would give 9)
        load_pos(0);
        i_step = 1'b1; i_in_valid = 1'b1; i_in_dir = 1'b0; i_in_data = 6'd0;
        tick();
        i_step = 1'b0; i_in_valid = 1'b0;
        check("stepin_pos", 32'(o_pos), 32'd1);
        tick();
        check("stepin_valid", 32'(o_out_valid), 32'd1);
        check("stepin_data", 32'(o_out_data), 32'd4);
        tick();

        lookup(1'b0, 30, 0, 1'b1, "err30");
        check("err_pos", 32'(o_pos), 32'd1);
        lookup(1'b0, 0, 9, 1'b0, "after_err");

        load_pos(5);
        i_in_valid = 1'b1; i_in_data = 6'd2;
        tick();
        i_in_data = 6'd3;
        #2;
        rst_n = 1'b0;
        i_in_valid = 1'b0;
        #1;
        check("rstf_pos_low", 32'(o_pos), 32'd0);
        check("rstf_valid_low", 32'(o_out_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rstf_no_valid", 32'(o_out_valid), 32'd0);
        end
        check("rstf_pos", 32'(o_pos), 32'd0);
        lookup(1'b0, 7, 7, 1'b0, "rstf_id_fwd7");
        lookup(1'b1, 4, 4, 1'b0, "rstf_id_rev4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
